instr_fetch: RTL and testbench

Instruction-fetch stage for the experimental processor: owns the program counter, drives the address of the combinational instruction ROM, and registers the 28-bit word the ROM returns into an instruction register consumed by decode/execute. It holds its output while execute is stalled, e.g. during a multi-cycle `IMUL2`. It flushes to a bubble on a taken branch. It also keeps a saturating stall-cycle counter for bring-up.

---
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, registers the ROM word into the IR,
// holds on stall, inserts a one-cycle bubble on a taken branch.
module instr_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 28,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oInstrPC,
  output logic               oValid,
  output logic [15:0]        oStallCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               vld_q, vld_d;
  logic [15:0]        cnt_q, cnt_d;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      ir_q    <= NOP_WORD;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  // REDIRECT only marks the bubble cycle; it resolves exactly like RUN.
  always_comb begin
    state_d = RUN;
    unique case (state_q)
      RUN, REDIRECT, HOLD: begin
        if (iBranchTaken)  state_d = REDIRECT;
        else if (iStall)   state_d = HOLD;
        else               state_d = RUN;
      end
      default:             state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    ipc_d = ipc_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (iBranchTaken) begin
      pc_d  = iBranchTarget;
      ir_d  = NOP_WORD;
      vld_d = 1'b0;
    end else if (iStall) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else begin
      ir_d  = iInstruction;
      ipc_d = pc_q;
      vld_d = 1'b1;
      pc_d  = pc_q + 1'b1;
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = ir_q;
  assign oInstrPC     = ipc_q;
  assign oValid       = vld_q;
  assign oStallCount  = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed plan steps plus random traffic, all
// checked against an abstract PC/IR model fed by a behavioural ROM.
module tb_instr_fetch;
  localparam logic [27:0] NOP = 28'h0;

  logic        gclk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [27:0] rom_word;
  logic        stall, br;
  logic [15:0] tgt;
  logic [27:0] instr;
  logic [15:0] ipc;
  logic        vld;
  logic [15:0] scnt;

  logic [27:0] rom [0:65535];
  int checks = 0;
  int errors = 0;

  // abstract model state
  int          m_pc, m_ipc, m_cnt;
  logic [27:0] m_ir;
  logic        m_v;

  always #5 gclk = ~gclk;
  assign rom_word = rom[addr];

  instr_fetch #(.ADDR_W(16), .INSTR_W(28), .NOP_WORD(NOP)) dut (
    .Clock(gclk), .Reset(rst_n), .oAddress(addr), .iInstruction(rom_word),
    .iStall(stall), .iBranchTaken(br), .iBranchTarget(tgt),
    .oInstruction(instr), .oInstrPC(ipc), .oValid(vld), .oStallCount(scnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("oAddress", 32'(addr), 32'(m_pc));
    chk("oInstruction", 32'(instr), 32'(m_ir));
    chk("oInstrPC", 32'(ipc), 32'(m_ipc));
    chk("oValid", 32'(vld), 32'(m_v));
    chk("oStallCount", 32'(scnt), 32'(m_cnt));
  endtask

  // one clock edge: model follows the rules with plain integer arithmetic
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst_n = r; stall = s; br = b; tgt = t;
    if (!r) begin
      m_pc = 0; m_ir = NOP; m_ipc = 0; m_v = 1'b0; m_cnt = 0;
    end else if (b) begin
      m_pc = int'(t); m_ir = NOP; m_v = 1'b0;
    end else if (s) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_ir = rom[m_pc]; m_ipc = m_pc; m_v = 1'b1; m_pc = (m_pc + 1) % 65536;
    end
    @(posedge gclk); #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 28'($urandom);
    rom[3] = {4'hA, 4'd1, 4'd1, 4'd7, 12'h000}; // IMUL2 R1,R1,R7
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0;
    m_pc = 0; m_ir = NOP; m_ipc = 0; m_v = 1'b0; m_cnt = 0;

    // reset, junk on other inputs must not matter
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    chk("reset_valid", 32'(vld), 32'd0);
    chk("reset_ir", 32'(instr), 32'(NOP));

    // 4 free fetches
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0);
      chk("run_ipc", 32'(ipc), 32'(i));
    end
    chk("word3_imul2", 32'(instr), 32'({4'hA, 4'd1, 4'd1, 4'd7, 12'h000}));

    // 5-cycle stall while IR holds PC 3
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("stall_addr", 32'(addr), 32'd4);
    chk("stall_cnt", 32'(scnt), 32'd5);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("release_ipc", 32'(ipc), 32'd4);
    chk("release_ir", 32'(instr), 32'(rom[4]));

    // branch to 1 (PC is 5 here; behaviour is PC independent)
    step(1'b1, 1'b0, 1'b1, 16'h0001);
    chk("br_bubble", 32'(vld), 32'd0);
    chk("br_addr", 32'(addr), 32'd1);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("br_ipc", 32'(ipc), 32'd1);
    chk("br_ir", 32'(instr), 32'(rom[1]));

    // branch + stall together: branch wins, counter untouched
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    chk("brstall_cnt", 32'(scnt), 32'd5);
    chk("brstall_addr", 32'(addr), 32'h40);
    // stall during redirect holds the bubble
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("redir_stall_vld", 32'(vld), 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0);

    // branch to FFFF then wrap
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("wrap_ipc0", 32'(ipc), 32'hFFFF);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("wrap_ipc1", 32'(ipc), 32'h0000);
    chk("wrap_vld", 32'(vld), 32'd1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic r, s, b;
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      step(r, s, b, 16'($urandom));
    end

    // drive counter to FFFE, then saturate
    while (m_cnt < 65534) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("pre_sat", 32'(scnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("sat", 32'(scnt), 32'hFFFF);

    // reset in the middle of a stall
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("midstall_cnt", 32'(scnt), 32'd0);
    chk("midstall_addr", 32'(addr), 32'd0);
    chk("midstall_vld", 32'(vld), 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("post_rst_ir", 32'(instr), 32'(rom[0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
